// File: rtl/exc_stall_sequencer_pkg.sv
// Shared types and sizing helpers for the exception/stall sequencer and the
// decode controller that sits next to it.
package exc_stall_sequencer_pkg;

    // Interrupt sequencing states: idle, waiting for a delay slot to clear, taking.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        TAKE      = 2'd2
    } exc_state_t;

    // Default block dimensions.
    localparam int NUM_IRQ_DEF     = 6;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Width of a counter that must hold the larger of the two MD latencies.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_cycles + 1);
    endfunction

    localparam int MD_CNT_W = md_cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

    // ALU operation encodings used by the decode controller.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluop_t;

    // Branch comparison encodings used by the decode controller.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LEZ  = 3'd3,
        BR_GTZ  = 3'd4,
        BR_LTZ  = 3'd5,
        BR_GEZ  = 3'd6
    } branch_type_t;

endpackage

// File: rtl/exc_stall_sequencer_md_busy_counter.sv
// HI/LO busy counter: loaded with the unit latency when a MULT/DIV issues,
// then counts down to zero; busy while non-zero.
module exc_stall_sequencer_md_busy_counter
    import exc_stall_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mul,
    input  logic start_div,
    input  logic en,
    output logic busy
);

    localparam int            W       = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [W-1:0]  MULT_LD = W'(MULT_CYCLES);
    localparam logic [W-1:0]  DIV_LD  = W'(DIV_CYCLES);

    logic [W-1:0] r_md_cnt;

    // Load on an accepted start (en = ID not stalled), else saturate down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= '0;
        end else if (start_mul && en) begin
            r_md_cnt <= MULT_LD;
        end else if (start_div && en) begin
            r_md_cnt <= DIV_LD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - W'(1);
        end
    end

    assign busy = (r_md_cnt != '0);

endmodule

// File: rtl/exc_stall_sequencer.sv
// Hazard/exception sequencer beside the decode controller: latches masked
// interrupt lines, defers a committed interrupt past a branch delay slot,
// tracks MULT/DIV busy time and drives stall, flush and PC-write controls.
// All controls are per-cycle levels, except exl_set/exl_clr, which are
// single-cycle pulses; there is no valid/ready handshake on this block.
module exc_stall_sequencer
    import exc_stall_sequencer_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEF,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               ie,
    input  logic               exl,
    input  logic               id_uncertain_jump,
    input  logic               id_eret,
    input  logic               load_use_hazard,
    input  logic               md_start_mul,
    input  logic               md_start_div,
    input  logic               md_use,
    output logic               pipeline_stall,
    output logic               pc_write,
    output logic               if_flush,
    output logic               id_flush,
    output logic               exl_set,
    output logic               exl_clr,
    output logic [NUM_IRQ-1:0] irq_cause,
    output logic               md_busy,
    output exc_state_t         state_dbg
);

    exc_state_t         r_state;
    exc_state_t         w_state_nxt;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_irq_cause;
    logic               w_md_busy;
    logic               w_stall;
    logic               w_take_req;
    logic               w_eret_go;
    logic               w_capture;
    logic               w_in_take;

    assign w_stall    = load_use_hazard | (md_use & w_md_busy);
    assign w_take_req = (|r_irq_q) & ie & ~exl;
    assign w_eret_go  = id_eret & ~w_stall;
    assign w_in_take  = (r_state == TAKE);

    exc_stall_sequencer_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk       (clk),
        .reset     (reset),
        .start_mul (md_start_mul),
        .start_div (md_start_div),
        .en        (~w_stall),
        .busy      (w_md_busy)
    );

    // One-cycle sample of the masked interrupt lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_q <= '0;
        end else begin
            r_irq_q <= irq & irq_mask;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Cause is frozen at commit so later line changes cannot alter it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_cause <= '0;
        end else if (w_capture) begin
            r_irq_cause <= r_irq_q;
        end
    end

    // Next state: commit only on an unstalled non-eret cycle; a jump in ID
    // defers the take until its delay slot is in ID and unstalled.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take_req && !w_stall && !id_eret) begin
                    w_capture   = 1'b1;
                    w_state_nxt = id_uncertain_jump ? WAIT_SLOT : TAKE;
                end
            end
            WAIT_SLOT: begin
                if (!w_stall && !id_uncertain_jump) begin
                    w_state_nxt = TAKE;
                end
            end
            TAKE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pipeline controls; flush/eret outputs are held low while reset is asserted.
    always_comb begin
        pipeline_stall = w_stall;
        pc_write       = w_in_take | ~w_stall;
        id_flush       = reset & w_stall;
        if_flush       = reset & (w_in_take | w_eret_go);
        exl_clr        = reset & w_eret_go;
        exl_set        = w_in_take;
        irq_cause      = r_irq_cause;
        md_busy        = w_md_busy;
        state_dbg      = r_state;
    end

endmodule

// File: tb/tb_exc_stall_sequencer.sv
// Bench for exc_stall_sequencer: directed scenarios followed by random
// traffic, checked cycle by cycle against a behavioural model through an
// expected-output queue, plus directed point checks.
module tb_exc_stall_sequencer;
  import exc_stall_sequencer_pkg::*;

  localparam int N  = 6;
  localparam int MC = 5;
  localparam int DC = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] irq, irq_mask;
  logic         ie, exl, id_uncertain_jump, id_eret, load_use_hazard;
  logic         md_start_mul, md_start_div, md_use;
  logic         pipeline_stall, pc_write, if_flush, id_flush, exl_set, exl_clr, md_busy;
  logic [N-1:0] irq_cause;
  exc_state_t   state_dbg;

  exc_stall_sequencer #(.NUM_IRQ(N), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .irq               (irq),
    .irq_mask          (irq_mask),
    .ie                (ie),
    .exl               (exl),
    .id_uncertain_jump (id_uncertain_jump),
    .id_eret           (id_eret),
    .load_use_hazard   (load_use_hazard),
    .md_start_mul      (md_start_mul),
    .md_start_div      (md_start_div),
    .md_use            (md_use),
    .pipeline_stall    (pipeline_stall),
    .pc_write          (pc_write),
    .if_flush          (if_flush),
    .id_flush          (id_flush),
    .exl_set           (exl_set),
    .exl_clr           (exl_clr),
    .irq_cause         (irq_cause),
    .md_busy           (md_busy),
    .state_dbg         (state_dbg)
  );

  typedef struct packed {
    logic         rst;
    logic [N-1:0] irq;
    logic [N-1:0] mask;
    logic         ie;
    logic         exl;
    logic         jmp;
    logic         eret;
    logic         lu;
    logic         smul;
    logic         sdiv;
    logic         muse;
  } stim_t;

  // ---------------- reference model ----------------
  // Abstract view: remaining busy cycles, sampled lines, a committed
  // interrupt that is either waiting for its slot or firing this cycle.
  int           m_cnt;
  logic [N-1:0] m_irq_s;
  logic [N-1:0] m_cause;
  bit           m_wait;
  bit           m_fire;
  bit           m_prev_jmp;

  logic [12:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    m_cnt = 0; m_irq_s = '0; m_cause = '0;
    m_wait = 0; m_fire = 0; m_prev_jmp = 0;
  endtask

  // Output order: stall, pc_write, if_flush, id_flush, exl_set, exl_clr, md_busy, cause
  function automatic logic [12:0] model_outputs(input stim_t s);
    logic busy, stall, eret_go;
    busy    = (m_cnt > 0);
    stall   = s.lu | (s.muse & busy);
    eret_go = s.eret & ~stall;
    return {stall, (m_fire | ~stall), s.rst & (m_fire | eret_go), s.rst & stall,
            logic'(m_fire), s.rst & eret_go, busy, m_cause};
  endfunction

  task automatic model_step(input stim_t s);
    logic busy, stall, take_req;
    busy     = (m_cnt > 0);
    stall    = s.lu | (s.muse & busy);
    take_req = (m_irq_s != '0) && s.ie && !s.exl;
    if (!s.rst) begin
      model_reset();
      return;
    end
    if (s.smul && !stall)      m_cnt = MC;
    else if (s.sdiv && !stall) m_cnt = DC;
    else if (m_cnt > 0)        m_cnt = m_cnt - 1;
    if (m_fire) begin
      m_fire = 0;
    end else if (m_wait) begin
      if (!stall && !s.jmp) begin m_wait = 0; m_fire = 1; end
    end else if (take_req && !stall && !s.eret) begin
      m_cause = m_irq_s;
      if (s.jmp) m_wait = 1; else m_fire = 1;
    end
    m_prev_jmp = s.jmp && !stall;
    m_irq_s = s.irq & s.mask;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rst; irq = s.irq; irq_mask = s.mask; ie = s.ie; exl = s.exl;
    id_uncertain_jump = s.jmp; id_eret = s.eret; load_use_hazard = s.lu;
    md_start_mul = s.smul; md_start_div = s.sdiv; md_use = s.muse;
    if (!s.rst) model_reset();
    exp_q.push_back(model_outputs(s));
    model_step(s);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '0; s.rst = 1'b1; s.mask = '1; s.ie = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int r;
    s = quiet();
    s.rst  = ($urandom_range(0, 299) != 0);
    s.mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
    s.ie   = ($urandom_range(0, 7) != 0);
    s.exl  = ($urandom_range(0, 5) == 0);
    s.irq  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
    s.jmp  = ($urandom_range(0, 3) == 0);
    s.lu   = ($urandom_range(0, 6) == 0);
    r = $urandom_range(0, 11);
    s.smul = (r == 0);
    s.sdiv = (r == 1);
    s.muse = s.smul | s.sdiv | ($urandom_range(0, 4) == 0);
    s.eret = ($urandom_range(0, 19) == 0) && !m_wait && !m_prev_jmp;
    if (m_fire) begin
      s.lu = 1'b0; s.eret = 1'b0;
      if (m_cnt > 0) begin s.muse = 1'b0; s.smul = 1'b0; s.sdiv = 1'b0; end
    end
    return s;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [12:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {pipeline_stall, pc_write, if_flush, id_flush, exl_set, exl_clr, md_busy, irq_cause};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL out_vec t=%0t got=%b exp=%b", $time, g, e);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    int first, n, cnt;
    rst_n = 1'b0; irq = '0; irq_mask = '0; ie = 0; exl = 0;
    id_uncertain_jump = 0; id_eret = 0; load_use_hazard = 0;
    md_start_mul = 0; md_start_div = 0; md_use = 0;
    model_reset();

    // Reset with all lines high, then release: exl_set two cycles later.
    s = quiet(); s.rst = 1'b0; s.irq = '1;
    repeat (3) drive(s);
    #2;
    check1("rst_exl_set", exl_set, 0);
    check1("rst_state", state_dbg, IDLE);
    check1("rst_cause", irq_cause, 0);
    check1("rst_md_busy", md_busy, 0);
    s.rst = 1'b1;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      drive(s);
      #2;
      if (exl_set && first < 0) first = i;
    end
    check1("release_take_lat", first, 2);
    s = quiet(); s.exl = 1'b1;
    repeat (4) drive(s);

    // Single line, no jump: one-cycle take at t+2 with cause 000100.
    s = quiet(); s.irq = 6'b000100; drive(s);
    s.irq = '0; drive(s);
    drive(s); #2;
    check1("t2_exl_set", exl_set, 1);
    check1("t2_if_flush", if_flush, 1);
    check1("t2_cause", irq_cause, 6'b000100);
    drive(s); #2;
    check1("t2_exl_set_off", exl_set, 0);

    // Jump at decision: wait for an unstalled non-jump delay slot.
    s = quiet(); s.irq = 6'b000100; drive(s);
    s.irq = '0; s.jmp = 1'b1; drive(s);
    s.jmp = 1'b0; s.lu = 1'b1; drive(s); #2;
    check1("t3_wait_state", state_dbg, WAIT_SLOT);
    check1("t3_no_take_stalled", exl_set, 0);
    s.lu = 1'b0; drive(s); #2;
    check1("t3_no_take_yet", exl_set, 0);
    drive(s); #2;
    check1("t3_take", exl_set, 1);
    check1("t3_cause", irq_cause, 6'b000100);
    drive(s);

    // MD busy stalls: md_use right after a start stalls for the full latency.
    s = quiet(); repeat (2) drive(s);
    s.smul = 1'b1; s.muse = 1'b1; drive(s);
    s.smul = 1'b0; n = 0;
    for (int k = 0; k < 40; k++) begin
      drive(s); #2;
      if (!pipeline_stall) break;
      n++;
    end
    check1("t4_mul_stall_cycles", n, MC);
    s = quiet(); s.sdiv = 1'b1; s.muse = 1'b1; drive(s);
    s.sdiv = 1'b0; n = 0;
    for (int k = 0; k < 40; k++) begin
      drive(s); #2;
      if (!pipeline_stall) break;
      n++;
    end
    check1("t4_div_stall_cycles", n, DC);

    // eret wins over a pending request; no take while exl stays set.
    s = quiet(); s.exl = 1'b1; s.irq = 6'b000001;
    repeat (2) drive(s);
    s.exl = 1'b0; s.eret = 1'b1; drive(s); #2;
    check1("t5_exl_clr", exl_clr, 1);
    check1("t5_if_flush", if_flush, 1);
    check1("t5_exl_set", exl_set, 0);
    s.exl = 1'b1; s.eret = 1'b0; cnt = 0;
    for (int k = 0; k < 6; k++) begin
      drive(s); #2;
      if (exl_set) cnt++;
    end
    check1("t5_no_take", cnt, 0);

    // Asynchronous reset while waiting on a slot with MD busy.
    s = quiet(); s.sdiv = 1'b1; s.muse = 1'b1; drive(s);
    s = quiet(); s.irq = 6'b000100; drive(s);
    s.irq = '0; s.jmp = 1'b1; drive(s);
    drive(s); #2;
    check1("t6_pre_state", state_dbg, WAIT_SLOT);
    check1("t6_pre_busy", md_busy, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("t6_state", state_dbg, IDLE);
    check1("t6_md_busy", md_busy, 0);
    check1("t6_cause", irq_cause, 0);
    check1("t6_exl_set", exl_set, 0);
    s = quiet(); s.rst = 1'b0; repeat (2) drive(s);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(rand_stim());
    end

    @(negedge clk); #1;
    check1("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
